// File: rtl/instruction_fetch_memory.sv
// instruction_fetch_memory
//   Instruction memory for the fetch stage. Reads are synchronous. Requests use a
//   valid/ready handshake, and responses come out of a small in-order FIFO.
//   A faulting request does not read memory. It returns instruction 0 with a fault
//   code, and it takes the same path and latency as a normal read.
// Ports
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   flush               drops the in-flight read and every buffered response
//   req_valid/ready     fetch request handshake; req_address is a byte address
//   resp_valid/ready    response handshake at the FIFO head
//   resp_instruction    head word (0 when empty or faulting)
//   resp_fault          00 ok, 01 misaligned, 10 out of range
//   fault_sticky        set when a faulting response is popped
//   prog_we/word_index/data  run-time program load port (read-first vs. fetch)
module instruction_fetch_memory #(
    parameter int    DATA_WIDTH = 32,
    parameter int    DEPTH_LOG2 = 8,
    parameter int    ADDR_WIDTH = 32,
    parameter int    FIFO_DEPTH = 3,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_address,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_instruction,
    output logic [1:0]            resp_fault,
    output logic                  fault_sticky,
    input  logic                  prog_we,
    input  logic [DEPTH_LOG2-1:0] prog_word_index,
    input  logic [DATA_WIDTH-1:0] prog_data
);
    localparam int LSB   = $clog2(DATA_WIDTH / 8);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    // The mask form keeps the alignment test valid when LSB is 0 (byte-wide words).
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'(1) << LSB) - 64'(1));

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Address decode
    logic                  misaligned, out_of_range;
    logic [1:0]            fault_code;
    logic [DEPTH_LOG2-1:0] word_index;

    assign misaligned   = |(req_address & ALIGN_MASK);
    assign out_of_range = |(req_address >> (LSB + DEPTH_LOG2));
    assign word_index   = DEPTH_LOG2'(req_address >> LSB);
    assign fault_code   = misaligned ? 2'b01 : (out_of_range ? 2'b10 : 2'b00);

    // Handshake. The in-flight read reserves a FIFO slot, so a push can never overflow.
    logic          inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW:0]   occupancy;
    logic          accept, push, pop;

    assign occupancy = (CW+1)'(count) + (CW+1)'(inflight);
    assign req_ready = !flush && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    assign push      = inflight && !flush;
    assign pop       = resp_valid && resp_ready;

    // Read stage. The non-blocking write makes a same-edge fetch return the old word.
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_fault;

    always_ff @(posedge clock) begin
        if (prog_we) mem[prog_word_index] <= prog_data;
        if (accept) begin
            rd_data  <= (fault_code == 2'b00) ? mem[word_index] : '0;
            rd_fault <= fault_code;
        end
    end

    // Response FIFO storage. Data is not reset; count gates visibility.
    logic [DATA_WIDTH-1:0] fifo_data  [FIFO_DEPTH];
    logic [1:0]            fifo_fault [FIFO_DEPTH];

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data[wr_ptr]  <= rd_data;
            fifo_fault[wr_ptr] <= rd_fault;
        end
    end

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight     <= 1'b0;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fault_sticky <= 1'b0;
        end else begin
            // A pop in the flush cycle still counts as delivered.
            if (pop && resp_fault != 2'b00) fault_sticky <= 1'b1;
            inflight <= accept;
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_next(wr_ptr);
                if (pop)  rd_ptr <= ptr_next(rd_ptr);
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign resp_valid       = (count != '0);
    assign resp_instruction = resp_valid ? fifo_data[rd_ptr]  : '0;
    assign resp_fault       = resp_valid ? fifo_fault[rd_ptr] : 2'b00;
endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Directed bench for instruction_fetch_memory with default parameters.
// The program is loaded through the prog port: word0/word1 hold the two
// test instructions, and word i (i >= 2) holds 0x10000000 + i.
module tb_instruction_fetch_memory;
    logic        clock = 1'b0;
    logic        reset_n, flush, req_valid, req_ready, resp_valid, resp_ready;
    logic [31:0] req_address, resp_instruction, prog_data;
    logic [1:0]  resp_fault;
    logic        fault_sticky, prog_we;
    logic [7:0]  prog_word_index;

    int errors = 0;
    int checks = 0;

    instruction_fetch_memory dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_instruction(resp_instruction), .resp_fault(resp_fault),
        .fault_sticky(fault_sticky), .prog_we(prog_we),
        .prog_word_index(prog_word_index), .prog_data(prog_data)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] expw(input int i);
        if (i == 0) return 32'h2008_0005;
        if (i == 1) return 32'h2009_000A;
        return 32'h1000_0000 + 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One isolated fetch with resp_ready=1: response appears after the second edge.
    task automatic fetch_one(input string tag, input logic [31:0] a,
                             input logic [31:0] ei, input logic [1:0] ef);
        req_valid = 1'b1; req_address = a;
        tick();
        req_valid = 1'b0;
        chk({tag, "_lat"}, 32'(resp_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_instr"}, resp_instruction, ei);
        chk({tag, "_fault"}, 32'(resp_fault), 32'(ef));
        tick();
        chk({tag, "_empty"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int acc;
        reset_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_address = '0; prog_we = 1'b0; prog_word_index = '0; prog_data = '0;
        tick();
        chk("rst_valid",  32'(resp_valid), 32'd0);
        chk("rst_instr",  resp_instruction, 32'd0);
        chk("rst_fault",  32'(resp_fault), 32'd0);
        chk("rst_sticky", 32'(fault_sticky), 32'd0);
        reset_n = 1'b1;
        tick();

        // Program load
        for (int i = 0; i < 21; i++) begin
            prog_we = 1'b1; prog_word_index = 8'(i); prog_data = expw(i);
            tick();
        end
        prog_we = 1'b0;
        chk("idle_ready", 32'(req_ready), 32'd1);

        // Test 1: back-to-back 0x0, 0x4
        resp_ready = 1'b1; req_valid = 1'b1; req_address = 32'h0;
        tick();
        chk("t1_lat", 32'(resp_valid), 32'd0);
        req_address = 32'h4;
        tick();
        req_valid = 1'b0;
        chk("t1_v0", 32'(resp_valid), 32'd1);
        chk("t1_w0", resp_instruction, expw(0));
        chk("t1_f0", 32'(resp_fault), 32'd0);
        tick();
        chk("t1_v1", 32'(resp_valid), 32'd1);
        chk("t1_w1", resp_instruction, expw(1));
        tick();
        chk("t1_empty", 32'(resp_valid), 32'd0);

        // Test 2: faults
        fetch_one("t2_mis", 32'h2, 32'h0, 2'b01);
        chk("t2_sticky", 32'(fault_sticky), 32'd1);
        fetch_one("t2_oor", 32'h400, 32'h0, 2'b10);
        fetch_one("t2_both", 32'h402, 32'h0, 2'b01);

        // Test 3: backpressure, 5 cycles of held request
        resp_ready = 1'b0; req_valid = 1'b1; acc = 0; req_address = 32'h0;
        for (int i = 0; i < 5; i++) begin
            if (req_ready) acc++;
            tick();
            if (acc > 0) req_address = 32'(acc * 4);
        end
        req_valid = 1'b0;
        chk("t3_accepted", 32'(acc), 32'd3);
        chk("t3_notready", 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("t3_v", 32'(resp_valid), 32'd1);
            chk("t3_w", resp_instruction, expw(k));
            tick();
        end
        chk("t3_empty", 32'(resp_valid), 32'd0);
        chk("t3_ready", 32'(req_ready), 32'd1);

        // Test 4: 16 streaming fetches, no bubbles
        req_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_address = 32'(i * 4);
            chk("t4_ready", 32'(req_ready), 32'd1);
            tick();
            if (i >= 1) begin
                chk("t4_v", 32'(resp_valid), 32'd1);
                chk("t4_w", resp_instruction, expw(i - 1));
            end
        end
        req_valid = 1'b0;
        tick();
        chk("t4_last", resp_instruction, expw(15));
        tick();
        chk("t4_empty", 32'(resp_valid), 32'd0);

        // Test 5: program write vs. same-cycle fetch (read-first)
        prog_we = 1'b1; prog_word_index = 8'd5; prog_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_address = 32'h14;
        tick();
        prog_we = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("t5_old", resp_instruction, expw(5));
        tick();
        chk("t5_new", resp_instruction, 32'hDEAD_BEEF);
        tick();
        chk("t5_empty", 32'(resp_valid), 32'd0);

        // Test 6: flush with 2 buffered + 1 in flight
        resp_ready = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_address = 32'(i * 4);
            tick();
        end
        req_valid = 1'b0;
        chk("t6_pre", 32'(resp_valid), 32'd1);
        flush = 1'b1;
        #1;
        chk("t6_flush_noready", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0;
        chk("t6_post", 32'(resp_valid), 32'd0);
        tick();
        chk("t6_nocancel", 32'(resp_valid), 32'd0);
        resp_ready = 1'b1;
        fetch_one("t6_w1", 32'h4, expw(1), 2'b00);

        // Reset mid-stream
        resp_ready = 1'b0; req_valid = 1'b1; req_address = 32'h8;
        tick();
        tick();
        chk("t6_rs_pre", 32'(resp_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rs_valid", 32'(resp_valid), 32'd0);
        chk("t6_rs_sticky", 32'(fault_sticky), 32'd0);
        chk("t6_rs_instr", resp_instruction, 32'd0);
        tick();
        chk("t6_rs_held", 32'(resp_valid), 32'd0);
        reset_n = 1'b1; req_valid = 1'b0;
        tick();
        chk("t6_rs_nopartial", 32'(resp_valid), 32'd0);
        resp_ready = 1'b1;
        fetch_one("t6_after0", 32'h0, expw(0), 2'b00);
        fetch_one("t6_after1", 32'h4, expw(1), 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
